// File: rtl/add_and_or_unit64.sv
// 64-bit execution slice: ripple-carry adder, bitwise AND/OR, and a 1-cycle registered result path.
// Optional registered flags (result_zero, result_ovf) are built when ADD_FLAGS_EN is defined.
module add_and_or_unit64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] and_ab,
  output logic [WIDTH-1:0] or_ab,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             out_valid
`ifdef ADD_FLAGS_EN
  ,
  output logic             result_zero,
  output logic             result_ovf
`endif
);

  typedef enum logic [1:0] {
    OpAdd  = 2'b00,
    OpAnd  = 2'b01,
    OpOr   = 2'b10,
    OpRsvd = 2'b11
  } op_e;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sel_res;
  logic             sel_cout;

  logic [WIDTH-1:0] result_d, result_q;
  logic             result_cout_d, result_cout_q;
  logic             out_valid_d, out_valid_q;

  // Explicit full-adder chain; carry[i] is the carry into bit i.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout   = carry[WIDTH];
  assign and_ab = a & b;
  assign or_ab  = a | b;

  always_comb begin
    sel_res  = '0;
    sel_cout = 1'b0;
    case (op_e'(op))
      OpAdd: begin
        sel_res  = sum;
        sel_cout = cout;
      end
      OpAnd:   sel_res = and_ab;
      OpOr:    sel_res = or_ab;
      default: sel_res = '0;
    endcase
  end

  // Result and carry hold when no valid operands arrive.
  always_comb begin
    result_d      = result_q;
    result_cout_d = result_cout_q;
    out_valid_d   = 1'b0;
    if (in_valid) begin
      result_d      = sel_res;
      result_cout_d = sel_cout;
      out_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q      <= '0;
      result_cout_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      result_q      <= result_d;
      result_cout_q <= result_cout_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign result      = result_q;
  assign result_cout = result_cout_q;
  assign out_valid   = out_valid_q;

`ifdef ADD_FLAGS_EN
  logic result_zero_d, result_zero_q;
  logic result_ovf_d, result_ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    result_zero_d = result_zero_q;
    result_ovf_d  = result_ovf_q;
    if (in_valid) begin
      result_zero_d = (sel_res == '0);
      result_ovf_d  = (op == OpAdd) & (carry[WIDTH] ^ carry[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_zero_q <= 1'b0;
      result_ovf_q  <= 1'b0;
    end else begin
      result_zero_q <= result_zero_d;
      result_ovf_q  <= result_ovf_d;
    end
  end

  assign result_zero = result_zero_q;
  assign result_ovf  = result_ovf_q;
`endif

endmodule

// File: tb/tb_add_and_or_unit64.sv
// Scoreboard bench for add_and_or_unit64: expected registered state is queued at drive time
// and popped one cycle later; combinational outputs are checked right after each drive.
module tb_add_and_or_unit64;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         cin;
  logic [1:0]   op;
  logic         in_valid;
  logic [W-1:0] sum, and_ab, or_ab, result;
  logic         cout, result_cout, out_valid;
`ifdef ADD_FLAGS_EN
  logic         result_zero, result_ovf;
`endif

  add_and_or_unit64 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .op         (op),
    .in_valid   (in_valid),
    .sum        (sum),
    .cout       (cout),
    .and_ab     (and_ab),
    .or_ab      (or_ab),
    .result     (result),
    .result_cout(result_cout),
    .out_valid  (out_valid)
`ifdef ADD_FLAGS_EN
    ,
    .result_zero(result_zero),
    .result_ovf (result_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         rcout;
    logic         vld;
    logic         zero;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [1:0]   op;
    logic         v;
    logic         rst;
  } stim_t;

  exp_t sb[$];
  exp_t m = '0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Drive inputs and advance the bench's own model of the registered path.
  task automatic drive(input stim_t s);
    logic [W:0]   full;
    logic [W-1:0] sel;
    logic         c;
    logic         ov;
    a = s.a; b = s.b; cin = s.cin; op = s.op; in_valid = s.v; rst = s.rst;
    full = {1'b0, s.a} + {1'b0, s.b} + {{W{1'b0}}, s.cin};
    c    = 1'b0;
    ov   = 1'b0;
    case (s.op)
      2'b00: begin
        sel = full[W-1:0];
        c   = full[W];
        ov  = (s.a[W-1] == s.b[W-1]) && (full[W-1] != s.a[W-1]);
      end
      2'b01:   sel = s.a & s.b;
      2'b10:   sel = s.a | s.b;
      default: sel = '0;
    endcase
    if (s.rst) m = '0;
    else if (s.v) begin
      m.res = sel; m.rcout = c; m.vld = 1'b1; m.zero = (sel == '0); m.ovf = ov;
    end else m.vld = 1'b0;
    sb.push_back(m);
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 3; i++) begin
      s = '{a: 64'd5, b: 64'd7, cin: 1'b0, op: 2'b00, v: 1'b1, rst: (i < 2)};
      drive(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({result, result_cout, out_valid} !== {e.res, e.rcout, e.vld}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got res=%h c=%b v=%b, want res=%h c=%b v=%b",
                 i, result, result_cout, out_valid, e.res, e.rcout, e.vld);
      end
    end
    n_tests++;
    if (result !== 64'd12 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_op: got res=%0d v=%b, want res=12 v=1", result, out_valid);
    end
  endtask

  task automatic test_add();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 2; i++) begin
      s = '{a: 64'd5, b: 64'd7, cin: i[0], op: 2'b00, v: 1'b1, rst: 1'b0};
      drive(s);
      #1;
      n_tests++;
      if (sum !== 64'(12 + i) || cout !== 1'b0) begin
        n_fail++;
        $display("FAIL add_comb[%0d]: got sum=%0d cout=%b, want sum=%0d cout=0",
                 i, sum, cout, 12 + i);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({result, result_cout, out_valid} !== {e.res, e.rcout, e.vld}) begin
        n_fail++;
        $display("FAIL add_reg[%0d]: got res=%h c=%b v=%b, want res=%h c=%b v=%b",
                 i, result, result_cout, out_valid, e.res, e.rcout, e.vld);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s[2];
    exp_t  e;
    s[0] = '{a: {W{1'b1}}, b: 64'd1, cin: 1'b0, op: 2'b00, v: 1'b1, rst: 1'b0};
    s[1] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, cin: 1'b0, op: 2'b00, v: 1'b1, rst: 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(s[i]);
      #1;
      n_tests++;
      if (i == 0 && (sum !== '0 || cout !== 1'b1)) begin
        n_fail++;
        $display("FAIL wrap_comb: got sum=%h cout=%b, want sum=0 cout=1", sum, cout);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({result, result_cout, out_valid} !== {e.res, e.rcout, e.vld}) begin
        n_fail++;
        $display("FAIL wrap_reg[%0d]: got res=%h c=%b v=%b, want res=%h c=%b v=%b",
                 i, result, result_cout, out_valid, e.res, e.rcout, e.vld);
      end
`ifdef ADD_FLAGS_EN
      n_tests++;
      if ({result_zero, result_ovf} !== {e.zero, e.ovf}) begin
        n_fail++;
        $display("FAIL wrap_flags[%0d]: got z=%b o=%b, want z=%b o=%b",
                 i, result_zero, result_ovf, e.zero, e.ovf);
      end
`endif
    end
    n_tests++;
    if (result !== 64'h8000_0000_0000_0000 || result_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_signed: got res=%h c=%b, want res=8000000000000000 c=0",
               result, result_cout);
    end
  endtask

  task automatic test_logic();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 2; i++) begin
      s = '{a: 64'hF0F0_F0F0_F0F0_F0F0, b: 64'hFF00_FF00_FF00_FF00, cin: 1'b1,
            op: (i == 0) ? 2'b01 : 2'b10, v: 1'b1, rst: 1'b0};
      drive(s);
      #1;
      n_tests++;
      if (and_ab !== 64'hF000_F000_F000_F000 || or_ab !== 64'hFFF0_FFF0_FFF0_FFF0) begin
        n_fail++;
        $display("FAIL logic_comb[%0d]: got and=%h or=%h, want and=F000F000F000F000 or=FFF0FFF0FFF0FFF0",
                 i, and_ab, or_ab);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({result, result_cout, out_valid} !== {e.res, e.rcout, e.vld}) begin
        n_fail++;
        $display("FAIL logic_reg[%0d]: got res=%h c=%b v=%b, want res=%h c=%b v=%b",
                 i, result, result_cout, out_valid, e.res, e.rcout, e.vld);
      end
    end
  endtask

  task automatic test_hold_reserved();
    stim_t s;
    exp_t  e;
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      s  = '{a: ra, b: rb, cin: 1'b1, op: (i == 3) ? 2'b11 : 2'(i), v: (i == 3), rst: 1'b0};
      drive(s);
      #1;
      n_tests++;
      if ({cout, sum} !== ({1'b0, ra} + {1'b0, rb} + 65'd1) || and_ab !== (ra & rb) ||
          or_ab !== (ra | rb)) begin
        n_fail++;
        $display("FAIL hold_comb[%0d]: got sum=%h cout=%b and=%h or=%h", i, sum, cout,
                 and_ab, or_ab);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({result, result_cout, out_valid} !== {e.res, e.rcout, e.vld}) begin
        n_fail++;
        $display("FAIL hold_reg[%0d]: got res=%h c=%b v=%b, want res=%h c=%b v=%b",
                 i, result, result_cout, out_valid, e.res, e.rcout, e.vld);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[7];
    exp_t  e;
    s[0] = '{a: 64'd100, b: 64'd23, cin: 1'b1, op: 2'b00, v: 1'b1, rst: 1'b0};
    s[1] = '{a: 64'hFFFF_0000_FFFF_0000, b: 64'h0F0F_0F0F_0F0F_0F0F, cin: 1'b0, op: 2'b01,
             v: 1'b1, rst: 1'b0};
    s[2] = '{a: 64'h1234_0000_0000_0000, b: 64'h0000_0000_0000_5678, cin: 1'b0, op: 2'b10,
             v: 1'b1, rst: 1'b0};
    s[3] = '{a: {W{1'b1}}, b: {W{1'b1}}, cin: 1'b1, op: 2'b00, v: 1'b1, rst: 1'b0};
    s[4] = '{a: 64'hFFFF_0000_FFFF_0000, b: 64'h0F0F_0F0F_0F0F_0F0F, cin: 1'b0, op: 2'b01,
             v: 1'b1, rst: 1'b1};
    s[5] = s[2];
    s[6] = '{a: 64'd0, b: 64'd0, cin: 1'b0, op: 2'b00, v: 1'b0, rst: 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({result, result_cout, out_valid} !== {e.res, e.rcout, e.vld}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got res=%h c=%b v=%b, want res=%h c=%b v=%b",
                 i, result, result_cout, out_valid, e.res, e.rcout, e.vld);
      end
`ifdef ADD_FLAGS_EN
      n_tests++;
      if ({result_zero, result_ovf} !== {e.zero, e.ovf}) begin
        n_fail++;
        $display("FAIL b2b_flags[%0d]: got z=%b o=%b, want z=%b o=%b",
                 i, result_zero, result_ovf, e.zero, e.ovf);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 2'b00;
    @(negedge clk);
    test_reset();
    test_add();
    test_wrap();
    test_logic();
    test_hold_reserved();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
